// File: rtl/bsg_vanilla_pkg.sv
// Shared vanilla-core package: barrier directions and barcfg CSR layout.
//   barrier_dir_e         : link direction index (P = local core, then mesh and ruche links)
//   barrier_root_code     : dest encoding meaning "this node is the root"
//   barcfg_*_offset_gp    : bit offsets of the src mask and dest fields inside barcfg
package bsg_vanilla_pkg;

  localparam int unsigned barrier_dirs_gp       = 7;
  localparam int unsigned barrier_root_code     = barrier_dirs_gp;
  localparam int unsigned barcfg_src_offset_gp  = 0;
  localparam int unsigned barcfg_dest_offset_gp = 16;

  typedef enum logic [2:0] {
    BarrierP  = 3'd0,
    BarrierW  = 3'd1,
    BarrierE  = 3'd2,
    BarrierN  = 3'd3,
    BarrierS  = 3'd4,
    BarrierRw = 3'd5,
    BarrierRe = 3'd6
  } barrier_dir_e;

  // Width that is never zero, even for a single-value encoding.
  function automatic int unsigned safe_clog2(input int unsigned x);
    return (x <= 1) ? 1 : $clog2(x);
  endfunction

endpackage

// File: rtl/vanilla_barrier_gather.sv
// Masked all-equal gather for the sense-reversal barrier.
//   clk_i, reset_i : clock, synchronous active-high reset
//   src_i          : gather mask, bit d = wait on input d
//   in_i           : effective input vector (bit 0 already replaced by the core Pi bit)
//   gather_o       : gather sense flop, toggles once every masked input has flipped
module vanilla_barrier_gather #(
  parameter int unsigned dirs_p = 7
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [dirs_p-1:0] src_i,
  input  logic [dirs_p-1:0] in_i,
  output logic              gather_o
);

  logic gather_r;
  logic all_match;

  // A masked input has arrived when it differs from the current sense.
  // An empty mask never matches, so an unconfigured node stays idle.
  always_comb begin
    all_match = (src_i != '0) &&
                (((in_i ^ {dirs_p{gather_r}}) & src_i) == src_i);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      gather_r <= 1'b0;
    end else if (all_match) begin
      gather_r <= ~gather_r;
    end
  end

  assign gather_o = gather_r;

endmodule

// File: rtl/vanilla_barrier_node.sv
// Per-tile barrier switch beside the vanilla core.
//   clk_i, reset_i    : clock, synchronous active-high reset
//   barrier_src_r_i   : gather mask from barcfg
//   barrier_dest_r_i  : parent direction from barcfg; barrier_dirs_p means root
//   pi_i              : core Pi bit, used as input direction 0
//   barrier_data_i    : link inputs from neighbours (bit 0 ignored)
//   barrier_data_o    : link outputs (bit 0 tied low)
//   po_o              : release bit returned to the core
//   pending_o         : core barrier still outstanding (pi_i != po_o)
//   epoch_o           : number of release toggles since reset, wrapping
module vanilla_barrier_node
  import bsg_vanilla_pkg::*;
#(
  parameter  int unsigned barrier_dirs_p     = 7,
  parameter  int unsigned epoch_width_p      = 16,
  localparam int unsigned barrier_lg_dirs_lp = safe_clog2(barrier_dirs_p + 1)
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic [barrier_dirs_p-1:0]     barrier_src_r_i,
  input  logic [barrier_lg_dirs_lp-1:0] barrier_dest_r_i,
  input  logic                          pi_i,
  input  logic [barrier_dirs_p-1:0]     barrier_data_i,
  output logic [barrier_dirs_p-1:0]     barrier_data_o,
  output logic                          po_o,
  output logic                          pending_o,
  output logic [epoch_width_p-1:0]      epoch_o
);

  localparam logic [barrier_lg_dirs_lp-1:0] RootCode = barrier_lg_dirs_lp'(barrier_dirs_p);
  localparam logic [barrier_lg_dirs_lp-1:0] LocalCode = barrier_lg_dirs_lp'(BarrierP);

  logic [barrier_dirs_p-1:0] in_vec;
  logic                      gather_r;
  logic                      release_r, release_d;
  logic [epoch_width_p-1:0]  epoch_r;
  logic                      is_root, dest_valid;
  logic                      unused_data0;

  // Link bit 0 has no neighbour; the local core's Pi takes its place.
  assign in_vec       = {barrier_data_i[barrier_dirs_p-1:1], pi_i};
  assign unused_data0 = barrier_data_i[0];

  vanilla_barrier_gather #(
    .dirs_p (barrier_dirs_p)
  ) u_gather (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .src_i    (barrier_src_r_i),
    .in_i     (in_vec),
    .gather_o (gather_r)
  );

  assign is_root    = (barrier_dest_r_i == RootCode);
  assign dest_valid = ((barrier_dest_r_i < RootCode) && (barrier_dest_r_i != LocalCode)) ||
                      is_root;

  always_comb begin
    release_d = release_r;
    if (is_root) begin
      release_d = gather_r;
    end else if (dest_valid) begin
      release_d = barrier_data_i[barrier_dest_r_i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      release_r <= 1'b0;
      epoch_r   <= '0;
    end else begin
      release_r <= release_d;
      if (release_d != release_r) begin
        epoch_r <= epoch_r + 1'b1;
      end
    end
  end

  // Parent link carries the gathered bit upward; every other link relays release down.
  always_comb begin
    barrier_data_o = '0;
    for (int d = 1; d < int'(barrier_dirs_p); d++) begin
      if (dest_valid && !is_root && (barrier_dest_r_i == barrier_lg_dirs_lp'(d))) begin
        barrier_data_o[d] = gather_r;
      end else begin
        barrier_data_o[d] = release_r;
      end
    end
  end

  assign po_o      = release_r;
  assign pending_o = pi_i ^ release_r;
  assign epoch_o   = epoch_r;

endmodule

// File: tb/tb_vanilla_barrier_node.sv
// Directed bench for vanilla_barrier_node: table of single-cycle vectors followed by
// hand-written multi-cycle sequences (root latency, mask gating, epoch wrap, reset).
module tb_vanilla_barrier_node;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [6:0]  barrier_src_r_i;
  logic [2:0]  barrier_dest_r_i;
  logic        pi_i;
  logic [6:0]  barrier_data_i;
  logic [6:0]  barrier_data_o;
  logic        po_o;
  logic        pending_o;
  logic [15:0] epoch_o;

  logic [6:0]  d2_data_o;
  logic        d2_po;
  logic        d2_pending;
  logic [1:0]  d2_epoch;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  vanilla_barrier_node #(
    .barrier_dirs_p (7),
    .epoch_width_p  (16)
  ) dut (
    .clk_i            (clk_i),
    .reset_i          (reset_i),
    .barrier_src_r_i  (barrier_src_r_i),
    .barrier_dest_r_i (barrier_dest_r_i),
    .pi_i             (pi_i),
    .barrier_data_i   (barrier_data_i),
    .barrier_data_o   (barrier_data_o),
    .po_o             (po_o),
    .pending_o        (pending_o),
    .epoch_o          (epoch_o)
  );

  // Narrow epoch counter copy, used to observe wrap-around.
  vanilla_barrier_node #(
    .barrier_dirs_p (7),
    .epoch_width_p  (2)
  ) dut2 (
    .clk_i            (clk_i),
    .reset_i          (reset_i),
    .barrier_src_r_i  (barrier_src_r_i),
    .barrier_dest_r_i (barrier_dest_r_i),
    .pi_i             (pi_i),
    .barrier_data_i   (barrier_data_i),
    .barrier_data_o   (d2_data_o),
    .po_o             (d2_po),
    .pending_o        (d2_pending),
    .epoch_o          (d2_epoch)
  );

  typedef struct {
    logic        rst;
    logic [6:0]  src;
    logic [2:0]  dest;
    logic        pi;
    logic [6:0]  din;
    logic [6:0]  exp_do;
    logic        exp_po;
    logic        exp_pend;
    logic [15:0] exp_ep;
  } vec_t;

  localparam int NumVecs = 19;
  vec_t vecs [NumVecs];

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic [6:0] src, input logic [2:0] dest,
                       input logic pi, input logic [6:0] din);
    reset_i          = rst;
    barrier_src_r_i  = src;
    barrier_dest_r_i = dest;
    pi_i             = pi;
    barrier_data_i   = din;
  endtask

  initial begin
    int bad;
    // rst, src, dest, pi, din | data_o, po, pending, epoch (state after the edge)
    vecs[0]  = '{1'b1, 7'h01, 3'd7, 1'b0, 7'h00, 7'h00, 1'b0, 1'b0, 16'd0}; // reset
    vecs[1]  = '{1'b0, 7'h01, 3'd7, 1'b0, 7'h00, 7'h00, 1'b0, 1'b0, 16'd0}; // idle root
    vecs[2]  = '{1'b0, 7'h01, 3'd7, 1'b1, 7'h00, 7'h00, 1'b0, 1'b1, 16'd0}; // gather set
    vecs[3]  = '{1'b0, 7'h01, 3'd7, 1'b1, 7'h00, 7'h7e, 1'b1, 1'b0, 16'd1}; // release
    vecs[4]  = '{1'b0, 7'h01, 3'd7, 1'b0, 7'h00, 7'h7e, 1'b1, 1'b1, 16'd1}; // 2nd barrier
    vecs[5]  = '{1'b0, 7'h01, 3'd7, 1'b0, 7'h00, 7'h00, 1'b0, 1'b0, 16'd2};
    vecs[6]  = '{1'b0, 7'h07, 3'd7, 1'b1, 7'h02, 7'h00, 1'b0, 1'b1, 16'd2}; // in2 missing
    vecs[7]  = '{1'b0, 7'h07, 3'd7, 1'b1, 7'h02, 7'h00, 1'b0, 1'b1, 16'd2};
    vecs[8]  = '{1'b0, 7'h07, 3'd7, 1'b1, 7'h06, 7'h00, 1'b0, 1'b1, 16'd2}; // all arrived
    vecs[9]  = '{1'b0, 7'h07, 3'd7, 1'b1, 7'h06, 7'h7e, 1'b1, 1'b0, 16'd3};
    vecs[10] = '{1'b1, 7'h01, 3'd2, 1'b0, 7'h00, 7'h00, 1'b0, 1'b0, 16'd0}; // reset
    vecs[11] = '{1'b0, 7'h01, 3'd2, 1'b1, 7'h00, 7'h04, 1'b0, 1'b1, 16'd0}; // up to E
    vecs[12] = '{1'b0, 7'h01, 3'd2, 1'b1, 7'h04, 7'h7e, 1'b1, 1'b0, 16'd1}; // parent release
    vecs[13] = '{1'b0, 7'h01, 3'd0, 1'b0, 7'h00, 7'h7e, 1'b1, 1'b1, 16'd1}; // dest P holds
    vecs[14] = '{1'b0, 7'h01, 3'd0, 1'b0, 7'h00, 7'h7e, 1'b1, 1'b1, 16'd1};
    vecs[15] = '{1'b1, 7'h00, 3'd7, 1'b0, 7'h00, 7'h00, 1'b0, 1'b0, 16'd0}; // reset
    vecs[16] = '{1'b0, 7'h00, 3'd7, 1'b1, 7'h00, 7'h00, 1'b0, 1'b1, 16'd0}; // zero mask
    vecs[17] = '{1'b0, 7'h00, 3'd7, 1'b0, 7'h00, 7'h00, 1'b0, 1'b0, 16'd0};
    vecs[18] = '{1'b0, 7'h00, 3'd7, 1'b1, 7'h00, 7'h00, 1'b0, 1'b1, 16'd0};

    drive(1'b1, 7'h00, 3'd7, 1'b0, 7'h00);
    step();

    for (int i = 0; i < NumVecs; i++) begin
      drive(vecs[i].rst, vecs[i].src, vecs[i].dest, vecs[i].pi, vecs[i].din);
      step();
      check($sformatf("vec%0d", i),
            64'({barrier_data_o, po_o, pending_o, epoch_o}),
            64'({vecs[i].exp_do, vecs[i].exp_po, vecs[i].exp_pend, vecs[i].exp_ep}));
    end

    // Root latency: Pi rises, pending for two edges, Po on the second.
    drive(1'b1, 7'h01, 3'd7, 1'b0, 7'h00);
    step();
    reset_i = 1'b0;
    for (int i = 0; i < 9; i++) step();
    pi_i = 1'b1;
    #1;
    check("lat_pend0", 64'(pending_o), 64'd1);
    step();
    check("lat_edge1", 64'({po_o, pending_o}), 64'b01);
    step();
    check("lat_edge2", 64'({po_o, pending_o, epoch_o}), 64'({2'b10, 16'd1}));

    // Mask gating: one missing input holds the barrier indefinitely.
    drive(1'b1, 7'h07, 3'd7, 1'b0, 7'h00);
    step();
    drive(1'b0, 7'h07, 3'd7, 1'b1, 7'h02);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (po_o !== 1'b0 || pending_o !== 1'b1 || barrier_data_o !== 7'h00) bad++;
    end
    check("gate_hold20", 64'(bad), 64'd0);
    barrier_data_i = 7'h06;
    step();
    check("gate_edge1", 64'(po_o), 64'd0);
    step();
    check("gate_edge2", 64'({po_o, barrier_data_o}), 64'({1'b1, 7'h7e}));

    // Six barriers: wide counter reads 6, 2-bit counter wraps to 2.
    drive(1'b1, 7'h01, 3'd7, 1'b0, 7'h00);
    step();
    reset_i = 1'b0;
    for (int b = 0; b < 6; b++) begin
      pi_i = ~pi_i;
      step();
      step();
      step();
    end
    check("wrap_po", 64'({po_o, pending_o}), 64'b00);
    check("wrap_epoch16", 64'(epoch_o), 64'd6);
    check("wrap_epoch2", 64'(d2_epoch), 64'd2);

    // Reset while gather is set but release not yet.
    drive(1'b1, 7'h01, 3'd7, 1'b0, 7'h00);
    step();
    reset_i = 1'b0;
    pi_i    = 1'b1;
    step();
    check("mid_pre", 64'({po_o, pending_o}), 64'b01);
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    check("mid_reset", 64'({barrier_data_o, po_o, pending_o, epoch_o}),
          64'({7'h00, 1'b0, 1'b1, 16'd0}));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
